// File: rtl/lock_key_pkg.sv
// Shared constants, state encoding and error codes for the c432 unlock-key loader.
package lock_key_pkg;

   localparam int unsigned NUM_MUX_KEY = 4;
   localparam int unsigned NUM_XOR_KEY = 38;
   localparam int unsigned KEY_W       = NUM_MUX_KEY + NUM_XOR_KEY;
   localparam int unsigned CRC_W       = 8;
   localparam int unsigned TIMEOUT     = 255;
   localparam int unsigned IDLE_W      = 8;
   localparam int unsigned CNT_W       = 6;

   localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT,
      TRAIL,
      CHECK,
      ACTIVE,
      FAIL
   } state_e;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_CRC     = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial MSB-first CRC-8 (init 0, no reflection, no final XOR).
module crc8_serial
   import lock_key_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   output logic [CRC_W-1:0] crc
);

   logic [CRC_W-1:0] crc_q;
   logic [CRC_W-1:0] crc_d;
   logic             fb;

   always_comb begin
      crc_d = crc_q;
      fb    = crc_q[CRC_W-1] ^ din;
      if (clr) begin
         crc_d = '0;
      end else if (en) begin
         crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) crc_q <= '0;
      else     crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

// File: rtl/lock_key_loader.sv
// Serial unlock-key loader: receives a 42-bit key plus CRC-8 trailer and drives the
// key bus only after the CRC verifies; the bus stays all-zero (core locked) otherwise.
module lock_key_loader
   import lock_key_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   kin_valid,
   input  logic                   kin_bit,
   output logic                   kin_ready,
   output logic [NUM_MUX_KEY-1:0] key_mux,
   output logic [NUM_XOR_KEY-1:0] key_xor,
   output logic                   key_valid,
   output logic                   busy,
   output logic [1:0]             err
);

   state_e state_q, state_d;

   logic                   kin_ready_q, kin_ready_d;
   logic [NUM_MUX_KEY-1:0] key_mux_q, key_mux_d;
   logic [NUM_XOR_KEY-1:0] key_xor_q, key_xor_d;
   logic                   key_valid_q, key_valid_d;
   logic                   busy_q, busy_d;
   logic [1:0]             err_q, err_d;
   logic [KEY_W-1:0]       stage_q, stage_d;
   logic [CRC_W-1:0]       rx_crc_q, rx_crc_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [IDLE_W-1:0]      idle_q, idle_d;

   logic             xfer;
   logic             last_key;
   logic             last_crc;
   logic             tmo;
   logic             crc_en;
   logic             crc_ok;
   logic [CRC_W-1:0] crc_calc;

   assign xfer     = kin_valid && kin_ready_q;
   assign last_key = (bit_cnt_q == CNT_W'(KEY_W - 1));
   assign last_crc = (bit_cnt_q == CNT_W'(CRC_W - 1));
   assign tmo      = !xfer && (idle_q == IDLE_W'(TIMEOUT - 1));
   assign crc_en   = xfer && (state_q == SHIFT) && !start;
   assign crc_ok   = (crc_calc == rx_crc_q);

   crc8_serial u_crc (
      .clk (clk),
      .rst (rst),
      .clr (start),
      .en  (crc_en),
      .din (kin_bit),
      .crc (crc_calc)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = SHIFT;
      end else begin
         case (state_q)
            SHIFT:   if (tmo) state_d = FAIL;
                     else if (xfer && last_key) state_d = TRAIL;
            TRAIL:   if (tmo) state_d = FAIL;
                     else if (xfer && last_crc) state_d = CHECK;
            CHECK:   state_d = crc_ok ? ACTIVE : FAIL;
            default: state_d = state_q;
         endcase
      end
   end

   // Key bus is loaded one cycle after CHECK passes, from the now-stable staging register.
   always_comb begin
      kin_ready_d = (state_d == SHIFT) || (state_d == TRAIL);
      key_mux_d   = key_mux_q;
      key_xor_d   = key_xor_q;
      key_valid_d = key_valid_q;
      busy_d      = busy_q;
      err_d       = err_q;
      stage_d     = stage_q;
      rx_crc_d    = rx_crc_q;
      bit_cnt_d   = bit_cnt_q;
      idle_d      = idle_q;
      if (start) begin
         key_mux_d   = '0;
         key_xor_d   = '0;
         key_valid_d = 1'b0;
         busy_d      = 1'b1;
         err_d       = ERR_NONE;
         stage_d     = '0;
         rx_crc_d    = '0;
         bit_cnt_d   = '0;
         idle_d      = '0;
      end else begin
         case (state_q)
            SHIFT, TRAIL: begin
               if (xfer) begin
                  idle_d = '0;
                  if (state_q == SHIFT) begin
                     stage_d   = {stage_q[KEY_W-2:0], kin_bit};
                     bit_cnt_d = last_key ? '0 : bit_cnt_q + CNT_W'(1);
                  end else begin
                     rx_crc_d  = {rx_crc_q[CRC_W-2:0], kin_bit};
                     bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  end
               end else if (tmo) begin
                  err_d   = ERR_TIMEOUT;
                  busy_d  = 1'b0;
                  idle_d  = '0;
                  stage_d = '0;
               end else begin
                  idle_d = idle_q + IDLE_W'(1);
               end
            end
            CHECK: begin
               busy_d = 1'b0;
               if (!crc_ok) err_d = ERR_CRC;
            end
            ACTIVE: begin
               if (!key_valid_q) begin
                  key_mux_d   = stage_q[NUM_MUX_KEY-1:0];
                  key_xor_d   = stage_q[KEY_W-1:NUM_MUX_KEY];
                  key_valid_d = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         kin_ready_q <= 1'b0;
         key_mux_q   <= '0;
         key_xor_q   <= '0;
         key_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= ERR_NONE;
         stage_q     <= '0;
         rx_crc_q    <= '0;
         bit_cnt_q   <= '0;
         idle_q      <= '0;
      end else begin
         kin_ready_q <= kin_ready_d;
         key_mux_q   <= key_mux_d;
         key_xor_q   <= key_xor_d;
         key_valid_q <= key_valid_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         stage_q     <= stage_d;
         rx_crc_q    <= rx_crc_d;
         bit_cnt_q   <= bit_cnt_d;
         idle_q      <= idle_d;
      end
   end

   assign kin_ready = kin_ready_q;
   assign key_mux   = key_mux_q;
   assign key_xor   = key_xor_q;
   assign key_valid = key_valid_q;
   assign busy      = busy_q;
   assign err       = err_q;

endmodule
